// File: rtl/conv_layer_spectral_mac_pkg.sv
// rtl/conv_layer_spectral_mac_pkg.sv - shared fixed-point complex types for the spectral datapath
package conv_layer_spectral_mac_pkg;
   localparam int FRAC = 16;
   localparam int DW   = 32;

   typedef struct packed {
      logic signed [DW-1:0] r;
      logic signed [DW-1:0] i;
   } complex_t;

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
endpackage

// File: rtl/conv_layer_spectral_mac_mul.sv
// rtl/conv_layer_spectral_mac_mul.sv - one registered fixed-point complex multiply
// 32x32 signed products summed in 64 bits, truncated to bits [FRAC+31:FRAC].
module complex_mul_fx
   import conv_layer_spectral_mac_pkg::*;
#(
   parameter int FRAC = conv_layer_spectral_mac_pkg::FRAC
) (
   input  logic     clk,
   input  logic     reset,
   input  complex_t a,
   input  complex_t b,
   output complex_t y
);
   logic signed [63:0] ac, bd, ad, bc;
   logic signed [31:0] re, im;

   always_comb begin
      ac = 64'(a.r) * 64'(b.r);
      bd = 64'(a.i) * 64'(b.i);
      ad = 64'(a.r) * 64'(b.i);
      bc = 64'(a.i) * 64'(b.r);
      re = 32'((ac - bd) >>> FRAC);
      im = 32'((ad + bc) >>> FRAC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y <= '0;
      end else begin
         y.r <= re;
         y.i <= im;
      end
   end
endmodule

// File: rtl/conv_layer_spectral_mac.sv
// rtl/conv_layer_spectral_mac.sv - spectral-domain conv MAC: tile x kernel, accumulated over channels
// Stages: tag (T), input+kernel capture (T+1), product (T+2), accumulate (T+3).
module conv_layer_spectral_mac
   import conv_layer_spectral_mac_pkg::*;
#(
   parameter int CH_W = 8,
   parameter int FRAC = conv_layer_spectral_mac_pkg::FRAC
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  next,
   input  complex_t [0:3][0:3]   in,
   input  logic [CH_W-1:0]       num_channels,
   input  logic                  kernel_wr,
   input  logic                  kernel_sel,
   input  logic [511:0]          kernel_line,
   output logic                  next_out,
   output complex_t [0:3][0:3]   out,
   output logic                  busy
);
   state_t              state;
   logic [CH_W-1:0]     cnt, lat, eff, cnt_nx;
   logic                tag;
   logic                v0, last0, v1, last1, v2, last2;
   complex_t [0:3][0:3] kern, in_q, kern_q, prod, acc, sum;

   always_comb begin
      eff    = (num_channels == '0) ? CH_W'(1) : num_channels;
      cnt_nx = cnt + CH_W'(1);
      tag    = (state == IDLE) ? (eff == CH_W'(1)) : (cnt_nx == lat);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         lat   <= '0;
         v0    <= 1'b0;
         last0 <= 1'b0;
      end else begin
         v0    <= next;
         last0 <= next & tag;
         if (next) begin
            if (state == IDLE) begin
               lat   <= eff;
               cnt   <= CH_W'(1);
               state <= tag ? IDLE : ACCUM;
            end else begin
               cnt <= cnt_nx;
               if (tag) state <= IDLE;
            end
         end
      end
   end

   // Kernel is copied alongside the tile so a same-cycle write only reaches later tiles.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1     <= 1'b0;
         last1  <= 1'b0;
         in_q   <= '0;
         kern_q <= '0;
         kern   <= '0;
      end else begin
         v1    <= v0;
         last1 <= last0;
         if (v0) begin
            in_q   <= in;
            kern_q <= kern;
         end
         if (kernel_wr) begin
            for (int j = 0; j < 4; j++) begin
               for (int k = 0; k < 4; k++) begin
                  if (kernel_sel) kern[j][k].i <= kernel_line[128*j+32*k +: 32];
                  else            kern[j][k].r <= kernel_line[128*j+32*k +: 32];
               end
            end
         end
      end
   end

   for (genvar j = 0; j < 4; j++) begin : g_row
      for (genvar k = 0; k < 4; k++) begin : g_col
         complex_mul_fx #(.FRAC(FRAC)) u_mul (
            .clk   (clk),
            .reset (reset),
            .a     (in_q[j][k]),
            .b     (kern_q[j][k]),
            .y     (prod[j][k])
         );
      end
   end

   always_comb begin
      sum = '0;
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < 4; k++) begin
            sum[j][k].r = acc[j][k].r + prod[j][k].r;
            sum[j][k].i = acc[j][k].i + prod[j][k].i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v2    <= 1'b0;
         last2 <= 1'b0;
         acc   <= '0;
         out   <= '0;
      end else begin
         v2    <= v1;
         last2 <= v1 & last1;
         if (v2) begin
            if (last2) begin
               out <= sum;
               acc <= '0;
            end else begin
               acc <= sum;
            end
         end
      end
   end

   assign next_out = last2;
   assign busy     = (state == ACCUM) | v0 | v1 | v2;
endmodule

// File: tb/tb_conv_layer_spectral_mac.sv
// tb/tb_conv_layer_spectral_mac.sv - scoreboard bench for conv_layer_spectral_mac
module tb_conv_layer_spectral_mac;
   import conv_layer_spectral_mac_pkg::*;

   typedef complex_t [0:3][0:3] tile_t;
   typedef struct {
      tile_t t;
      int    cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, next, kernel_wr, kernel_sel, next_out, busy;
   tile_t         tin, tout;
   logic [7:0]    num_channels;
   logic [511:0]  kernel_line;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   int    rst_req = 0, rst_seen = 0;
   int    idle_req = 0, idle_seen = 0;
   int    kw_cyc = -1;
   logic [31:0] kw_val = '0;
   bit    pend = 0;
   exp_t  cur;
   exp_t  sb[$];
   tile_t sq[$];
   tile_t eq[$];
   bit    lq[$];

   conv_layer_spectral_mac #(.CH_W(8), .FRAC(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .next         (next),
      .in           (tin),
      .num_channels (num_channels),
      .kernel_wr    (kernel_wr),
      .kernel_sel   (kernel_sel),
      .kernel_line  (kernel_line),
      .next_out     (next_out),
      .out          (tout),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic tile_t fill(input logic [31:0] r, input logic [31:0] i);
      tile_t t;
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++) begin
            t[j][k].r = r;
            t[j][k].i = i;
         end
      return t;
   endfunction

   task automatic step(input logic nx, input tile_t t, input logic kw, input logic ks, input logic [31:0] kv);
      next        = nx;
      tin         = t;
      kernel_wr   = kw;
      kernel_sel  = ks;
      kernel_line = {16{kv}};
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step(1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic wr_kernel(input logic [31:0] re, input logic [31:0] im);
      step(1'b0, '0, 1'b1, 1'b0, re);
      step(1'b0, '0, 1'b1, 1'b1, im);
   endtask

   // Issue queued tiles back to back; each tile's data follows its next by one cycle.
   task automatic play();
      int n = sq.size();
      int ei = 0;
      for (int c = 0; c <= n; c++) begin
         tile_t t = (c > 0) ? sq[c-1] : '0;
         if (c < n && lq[c]) begin
            sb.push_back('{t: eq[ei], cyc: cyc + 3});
            ei++;
         end
         step(c < n, t, (c == kw_cyc), 1'b0, kw_val);
      end
      sq.delete();
      lq.delete();
      eq.delete();
      kw_cyc = -1;
   endtask

   task automatic idle_check();
      idle(6);
      idle_req++;
      idle(1);
   endtask

   always @(negedge clk) begin
      if (pend) begin
         checks++;
         if (tout !== cur.t) begin
            errors++;
            for (int j = 0; j < 4; j++)
               for (int k = 0; k < 4; k++)
                  if (tout[j][k] !== cur.t[j][k] && pend) begin
                     $display("FAIL out_value cycle %0d elem [%0d][%0d] got r=%h i=%h want r=%h i=%h",
                              cyc, j, k, tout[j][k].r, tout[j][k].i, cur.t[j][k].r, cur.t[j][k].i);
                     pend = 0;
                  end
         end
         pend = 0;
      end
      if (next_out) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL next_out_unexpected cycle %0d got 1 want 0", cyc);
         end else begin
            cur = sb.pop_front();
            if (cyc != cur.cyc) begin
               errors++;
               $display("FAIL next_out_cycle got %0d want %0d", cyc, cur.cyc);
            end
            pend = 1;
         end
      end
      if (rst_req != rst_seen) begin
         rst_seen = rst_req;
         checks += 3;
         if (next_out !== 1'b0) begin errors++; $display("FAIL rst_next_out got %b want 0", next_out); end
         if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
         if (tout !== '0)       begin errors++; $display("FAIL rst_out got nonzero want 0"); end
      end
      if (idle_req != idle_seen) begin
         idle_seen = idle_req;
         checks += 2;
         if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
         if (sb.size() != 0 || pend) begin
            errors++;
            $display("FAIL idle_pending got %0d want 0", sb.size() + int'(pend));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle %0d got running want finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      tile_t a, b;
      reset = 1'b1;
      num_channels = 8'd1;
      // next and an imag kernel write during reset must both be ignored.
      step(1'b1, fill(32'h0001_0000, 0), 1'b1, 1'b1, 32'h0005_0000);
      step(1'b1, fill(32'h0001_0000, 0), 1'b1, 1'b1, 32'h0005_0000);
      reset = 1'b0;
      idle(1);
      rst_req++;
      idle(4);

      // identity kernel, one channel, two tiles back to back
      wr_kernel(32'h0001_0000, 32'h0);
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++) begin
            a[j][k].r = 32'((j*4+k) << 16);
            a[j][k].i = -32'((j*4+k) << 16);
            b[j][k].r = 32'((j*4+k) * 32'h2_0000 + 32'h1234);
            b[j][k].i = 32'h8000;
         end
      sq.push_back(a); lq.push_back(1); eq.push_back(a);
      sq.push_back(b); lq.push_back(1); eq.push_back(b);
      play();
      idle_check();

      // kernel = i: 2.0 -> 2.0i
      wr_kernel(32'h0, 32'h0001_0000);
      sq.push_back(fill(32'h0002_0000, 0)); lq.push_back(1); eq.push_back(fill(0, 32'h0002_0000));
      play();
      idle(3);

      // kernel 0.5 truncates toward minus infinity: 3 -> 1, -3 -> -2
      wr_kernel(32'h0000_8000, 32'h0);
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++) begin
            a[j][k].r = ((j + k) % 2 == 0) ? 32'sd3 : -32'sd3;
            a[j][k].i = 0;
            b[j][k].r = ((j + k) % 2 == 0) ? 32'h1 : 32'hFFFF_FFFE;
            b[j][k].i = 0;
         end
      sq.push_back(a); lq.push_back(1); eq.push_back(b);
      play();
      idle(3);

      // three channels of 1.0
      wr_kernel(32'h0001_0000, 32'h0);
      num_channels = 8'd3;
      for (int c = 0; c < 3; c++) begin
         sq.push_back(fill(32'h0001_0000, 0));
         lq.push_back(c == 2);
      end
      eq.push_back(fill(32'h0003_0000, 0));
      play();
      idle_check();

      // two 2-channel groups with no gap
      num_channels = 8'd2;
      sq.push_back(fill(32'h0001_0000, 0)); lq.push_back(0);
      sq.push_back(fill(32'h0002_0000, 0)); lq.push_back(1);
      sq.push_back(fill(32'h0005_0000, 0)); lq.push_back(0);
      sq.push_back(fill(32'hFFFF_0000, 0)); lq.push_back(1);
      eq.push_back(fill(32'h0003_0000, 0));
      eq.push_back(fill(32'h0004_0000, 0));
      play();
      idle(3);

      // wraparound
      sq.push_back(fill(32'h7FFF_0000, 0)); lq.push_back(0);
      sq.push_back(fill(32'h7FFF_0000, 0)); lq.push_back(1);
      eq.push_back(fill(32'hFFFE_0000, 0));
      play();
      idle(3);

      // kernel rewritten in the first tile's sample cycle: 1*1.0 + 1*3.0
      sq.push_back(fill(32'h0001_0000, 0)); lq.push_back(0);
      sq.push_back(fill(32'h0001_0000, 0)); lq.push_back(1);
      eq.push_back(fill(32'h0004_0000, 0));
      kw_cyc = 1;
      kw_val = 32'h0003_0000;
      play();
      idle_check();

      // reset after one of two tiles, then a fresh group
      step(1'b1, '0, 1'b0, 1'b0, '0);
      step(1'b0, fill(32'h0009_0000, 0), 1'b0, 1'b0, '0);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      rst_req++;
      idle(2);
      wr_kernel(32'h0001_0000, 32'h0);
      sq.push_back(fill(32'h0001_0000, 32'h0002_0000)); lq.push_back(0);
      sq.push_back(fill(32'h0001_0000, 32'h0002_0000)); lq.push_back(1);
      eq.push_back(fill(32'h0002_0000, 32'h0004_0000));
      play();

      for (int w = 0; w < 50 && (sb.size() > 0 || pend); w++) idle(1);
      idle_check();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_layer_spectral_mac.md
CONV_LAYER_SPECTRAL_MAC -- requirements
Module: conv_layer_spectral_mac

Interface
REQ-001 SHALL have parameter CH_W, default 8, meaning width of the channel-count input.
REQ-002 SHALL have parameter FRAC, default 16, meaning fraction bits of the signed fixed-point format.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port next, input, 1; pulse meaning the input tile is valid on the following cycle.
REQ-006 SHALL have port in, input, complex_t [0:3][0:3]; the FFT-domain input tile from the upstream 2D FFT.
REQ-007 SHALL have port num_channels, input, CH_W; number of input-channel tiles per output group.
REQ-008 SHALL have port kernel_wr, input, 1; kernel register write strobe.
REQ-009 SHALL have port kernel_sel, input, 1; 0 writes the real parts, 1 writes the imaginary parts.
REQ-010 SHALL have port kernel_line, input, 512; element [j][k] occupies bits 128*j+32*k+31 : 128*j+32*k.
REQ-011 SHALL have port next_out, output, 1; pulse meaning out is valid from the following cycle.
REQ-012 SHALL have port out, output, complex_t [0:3][0:3]; the accumulated spectral product for the downstream IFFT.
REQ-013 SHALL have port busy, output, 1; high in ACCUM state or while any pipeline stage holds a valid tile.

Function
REQ-014 SHALL sample in at the end of cycle T+1 when next is high in cycle T; next may be high on consecutive cycles, giving one tile per cycle.
REQ-015 SHALL multiply each sampled element by kernel[j][k]; real part = (a*c - b*d), imaginary part = (a*d + b*c).
REQ-016 Each multiply SHALL be 32x32 signed giving a 64-bit product; sum/difference in 64 bits; result = bits [FRAC+31:FRAC] (truncation, no rounding, no saturation).
REQ-017 Pipeline SHALL be: input register at end of T+1, product register at end of T+2, accumulate at end of T+3.
REQ-018 Accumulator SHALL be 32-bit two's complement per component and wrap on overflow.
REQ-019 Kernel registers SHALL be written at the clock edge ending a kernel_wr cycle.
REQ-020 The kernel value used for a tile SHALL be the one held in the cycle the tile is sampled; a write in that same cycle affects only later tiles.
REQ-021 FSM SHALL have two states, IDLE and ACCUM.
REQ-022 IDLE->ACCUM SHALL occur on next; at that point num_channels is latched (0 treated as 1) and the channel counter is set to 1.
REQ-023 In ACCUM, each next SHALL increment the counter.
REQ-024 The tile whose next makes counter == latched count SHALL be tagged last, and the FSM SHALL return to IDLE.
REQ-025 A next arriving in the IDLE cycle directly after a last tile SHALL start a new group with no bubble.
REQ-026 Every tile's tag SHALL travel with it through the pipeline.
REQ-027 For a last-tagged tile, the accumulate stage SHALL load out with acc+product and clear acc to 0 in the same edge.
REQ-028 For a last-tagged tile, next_out SHALL be high for exactly the cycle before out changes (next at T -> next_out in T+3, out valid from T+4).
REQ-029 out SHALL hold its value until the next group completes.
REQ-030 The first tile of a new group SHALL reach the accumulator no earlier than the clearing edge, so back-to-back groups never mix.
REQ-031 With num_channels == 1, every tile SHALL produce its own next_out.

Reset
REQ-032 While reset is high at an edge: FSM->IDLE; counter, pipeline valid and tag bits, accumulator, kernel registers and out SHALL all clear to 0; next_out=0; busy=0.
REQ-033 Reset mid-group SHALL discard all partial work, with no next_out for the aborted group.
REQ-034 next or kernel_wr asserted in a reset cycle SHALL be ignored.

Structure
REQ-035 complex_t and the FRAC constant SHALL come from the shared package/header already used by the FFT blocks; no new typedefs are local to this module.
REQ-036 A single sub-module, complex_mul_fx (one registered fixed-point complex multiply, 1-cycle latency), SHALL be instantiated 16 times.

Verification
REQ-037 Kernel all 1.0 (0x00010000 real, 0 imag), num_channels=1, in[j][k].r = j*4+k in Q16.16 -> next_out at T+3; out equals in.
REQ-038 Kernel = i (imag 1.0, real 0), in real 2.0 -> out.r=0, out.i=0x00020000 for every element.
REQ-039 num_channels=3, kernel 1.0, three back-to-back tiles of 1.0 -> one next_out, 3 cycles after the third next; out.r=0x00030000; busy low afterwards.
REQ-040 Two groups (num_channels=2) with no gap between groups -> two next_out pulses 2 cycles apart; second result not contaminated by the first.
REQ-041 Accumulating 0x7FFF0000 twice -> wraps to 0xFFFE0000; kernel rewritten between channels -> each tile uses the kernel present at its sample cycle.
REQ-042 Reset asserted after 1 of 2 tiles, then a fresh 2-tile group -> no spurious next_out; result reflects only the fresh group.
